// File: rtl/ram_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_bus_ctrl_if
// Bundle of the CPU/cache request bus and the RAM port-A lane bus that
// surround ram_bus_ctrl. Signal names are seen from the controller.
//
//   mem_addr_i   [31:0]     byte address of the request
//   mem_data_i   [31:0]     write data
//   mem_wr_i     [3:0]      byte-lane write strobes
//   mem_rd_i                read request
//   mem_burst_i             read is a 4-beat wrapping burst
//   mem_accept_o            request taken on the coming edge
//   mem_data_o   [31:0]     registered read data
//   mem_ack_o               one pulse per completed write or read beat
//   mem_last_o              final ack of a transfer
//   ram_addr_o   [SIZE-1:0] word address to all four lanes
//   ram_data_o   [31:0]     lane write data
//   ram_wr_o     [3:0]      per-lane write enable
//   ram_data_i   [31:0]     lane read data (registered-address RAM)
//
// Modports: slave = the controller, master = requester plus RAM side.
// ----------------------------------------------------------------------------
interface ram_bus_ctrl_if #(
    parameter int SIZE = 14
);
    logic [31:0]     mem_addr_i;
    logic [31:0]     mem_data_i;
    logic [3:0]      mem_wr_i;
    logic            mem_rd_i;
    logic            mem_burst_i;
    logic            mem_accept_o;
    logic [31:0]     mem_data_o;
    logic            mem_ack_o;
    logic            mem_last_o;
    logic [SIZE-1:0] ram_addr_o;
    logic [31:0]     ram_data_o;
    logic [3:0]      ram_wr_o;
    logic [31:0]     ram_data_i;

    modport slave (
        input  mem_addr_i, mem_data_i, mem_wr_i, mem_rd_i, mem_burst_i,
        input  ram_data_i,
        output mem_accept_o, mem_data_o, mem_ack_o, mem_last_o,
        output ram_addr_o, ram_data_o, ram_wr_o
    );

    modport master (
        output mem_addr_i, mem_data_i, mem_wr_i, mem_rd_i, mem_burst_i,
        output ram_data_i,
        input  mem_accept_o, mem_data_o, mem_ack_o, mem_last_o,
        input  ram_addr_o, ram_data_o, ram_wr_o
    );
endinterface

// File: rtl/ram_bus_ctrl.sv
// ----------------------------------------------------------------------------
// ram_bus_ctrl
// Bus-side controller in front of port A of a four-lane byte-wide dual-port
// RAM. Turns 32-bit memory requests into lane address/data/strobes, hides
// the RAM's one-cycle registered-address read latency and returns registered
// read data with an ack. Supports 4-beat wrapping (critical-word-first) read
// bursts for cache line fills.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    ram_bus_ctrl_if.slave (request bus + RAM lane bus)
// ----------------------------------------------------------------------------
module ram_bus_ctrl #(
    parameter int SIZE = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ram_bus_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        BURST = 2'd2,
        LAST  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      cnt;
    logic [SIZE-1:0] base;
    logic [31:0]     rd_data_p1;
    logic            ack_p1;
    logic            last_p1;

    logic [SIZE-1:0] word_addr;
    logic            wr_req;
    logic            rd_req;
    logic [1:0]      beat_lo;

    assign word_addr = bus.mem_addr_i[SIZE+1:2];
    assign wr_req    = |bus.mem_wr_i;
    // Any write strobe wins over a simultaneous read request.
    assign rd_req    = bus.mem_rd_i & ~wr_req;
    // Beat offset wraps inside the 4-word line.
    assign beat_lo   = base[1:0] + cnt;

    // Address bits outside the word index alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr_i[31:SIZE+2], bus.mem_addr_i[1:0]};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_nxt = bus.mem_burst_i ? BURST : RD;
                end
            end
            RD:      state_nxt = IDLE;
            BURST:   state_nxt = (cnt == 2'd3) ? LAST : BURST;
            LAST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_accept_o = (state == IDLE);
        bus.ram_addr_o   = word_addr;
        bus.ram_data_o   = bus.mem_data_i;
        bus.ram_wr_o     = 4'b0000;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    bus.ram_wr_o = bus.mem_wr_i;
                end
            end
            BURST:   bus.ram_addr_o = {base[SIZE-1:2], beat_lo};
            default: ;
        endcase
    end

    // Read-data capture, ack/last generation and burst bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= 2'd0;
            base       <= '0;
            rd_data_p1 <= 32'd0;
            ack_p1     <= 1'b0;
            last_p1    <= 1'b0;
        end else begin
            ack_p1  <= 1'b0;
            last_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        ack_p1  <= 1'b1;
                        last_p1 <= 1'b1;
                    end else if (rd_req && bus.mem_burst_i) begin
                        // Beat 0 address goes out this cycle as word_addr.
                        base <= word_addr;
                        cnt  <= 2'd1;
                    end
                end
                RD: begin
                    rd_data_p1 <= bus.ram_data_i;
                    ack_p1     <= 1'b1;
                    last_p1    <= 1'b1;
                end
                BURST: begin
                    rd_data_p1 <= bus.ram_data_i;
                    ack_p1     <= 1'b1;
                    cnt        <= cnt + 2'd1;
                end
                LAST: begin
                    rd_data_p1 <= bus.ram_data_i;
                    ack_p1     <= 1'b1;
                    last_p1    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_data_o = rd_data_p1;
    assign bus.mem_ack_o  = ack_p1;
    assign bus.mem_last_o = last_p1;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_bus_ctrl
// Bench for ram_bus_ctrl: a behavioural byte-lane RAM with registered read
// address, a requester that holds requests until accepted, and a timeline
// model that predicts every cycle's accept/ack/last/data from the request
// rules (write ack +1, single read ack +2, burst acks +2..+5).
// ----------------------------------------------------------------------------
module tb_ram_bus_ctrl;
    localparam int SIZE  = 14;
    localparam int DEPTH = 1 << SIZE;
    localparam int MAXC  = 8192;

    logic clk = 1'b0;
    logic rst;

    ram_bus_ctrl_if #(.SIZE(SIZE)) bus ();

    ram_bus_ctrl #(.SIZE(SIZE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM port A: byte-lane writes, address registered, data read from it.
    logic [31:0]     ram [0:DEPTH-1];
    logic [SIZE-1:0] ram_aq;
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++)
            if (bus.ram_wr_o[n]) ram[bus.ram_addr_o][8*n +: 8] <= bus.ram_data_o[8*n +: 8];
        ram_aq <= bus.ram_addr_o;
    end
    assign bus.ram_data_i = ram[ram_aq];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: golden memory plus per-cycle expectation timeline.
    logic [31:0] gold [0:DEPTH-1];
    bit          e_ack [0:MAXC-1];
    bit          e_last[0:MAXC-1];
    bit          e_rdv [0:MAXC-1];
    logic [31:0] e_dat [0:MAXC-1];
    logic [31:0] cur_data = 32'd0;
    int          busy_until = 0;

    always @(negedge clk) begin
        logic            idle;
        logic            req_wr;
        logic [SIZE-1:0] wa;
        logic [1:0]      lo;
        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                e_ack[cyc+k]  = 1'b0;
                e_last[cyc+k] = 1'b0;
                e_rdv[cyc+k]  = 1'b0;
            end
            cur_data   = 32'd0;
            busy_until = cyc;
        end else if (e_rdv[cyc]) begin
            cur_data = e_dat[cyc];
        end
        idle   = (cyc >= busy_until);
        req_wr = (bus.mem_wr_i != 4'd0);
        chk("ack",    bus.mem_ack_o,    e_ack[cyc]);
        chk("last",   bus.mem_last_o,   e_last[cyc]);
        chk("data",   bus.mem_data_o,   cur_data);
        chk("accept", bus.mem_accept_o, idle);
        chk("ram_wr", bus.ram_wr_o,     idle ? bus.mem_wr_i : 4'd0);
        if (!rst && idle && (req_wr || bus.mem_rd_i)) begin
            wa = bus.mem_addr_i[SIZE+1:2];
            if (req_wr) begin
                for (int n = 0; n < 4; n++)
                    if (bus.mem_wr_i[n]) gold[wa][8*n +: 8] = bus.mem_data_i[8*n +: 8];
                e_ack[cyc+1]  = 1'b1;
                e_last[cyc+1] = 1'b1;
                busy_until    = cyc + 1;
            end else if (!bus.mem_burst_i) begin
                e_ack[cyc+2]  = 1'b1;
                e_last[cyc+2] = 1'b1;
                e_rdv[cyc+2]  = 1'b1;
                e_dat[cyc+2]  = gold[wa];
                busy_until    = cyc + 2;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    lo = wa[1:0] + k[1:0];
                    e_ack[cyc+2+k] = 1'b1;
                    e_rdv[cyc+2+k] = 1'b1;
                    e_dat[cyc+2+k] = gold[{wa[SIZE-1:2], lo}];
                end
                e_last[cyc+5] = 1'b1;
                busy_until    = cyc + 5;
            end
        end
        cyc++;
    end

    // Requester: present a request and hold it until it is accepted.
    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       input logic r, input logic b);
        logic acc;
        int   t;
        bus.mem_addr_i  = a;
        bus.mem_data_i  = d;
        bus.mem_wr_i    = w;
        bus.mem_rd_i    = r;
        bus.mem_burst_i = b;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 12) begin
            @(negedge clk);
            acc = bus.mem_accept_o;
            @(posedge clk);
            #1;
            t++;
        end
        chk("req_accepted", acc, 1'b1);
        bus.mem_wr_i = 4'd0;
        bus.mem_rd_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] burst_exp [0:3];
    logic [31:0] a;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.mem_addr_i  = 32'd0;
        bus.mem_data_i  = 32'd0;
        bus.mem_wr_i    = 4'd0;
        bus.mem_rd_i    = 1'b0;
        bus.mem_burst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",    bus.mem_ack_o,    1'b0);
        chk("rst_last",   bus.mem_last_o,   1'b0);
        chk("rst_data",   bus.mem_data_o,   32'd0);
        chk("rst_accept", bus.mem_accept_o, 1'b1);
        rst = 1'b0;
        idle_cycles(2);

        // Write then single read of the same word.
        req(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        chk("wr_ack_c1", bus.mem_ack_o, 1'b1);
        req(32'h0000_0100, 32'd0, 4'h0, 1'b1, 1'b0);
        chk("rd_ack_c1",    bus.mem_ack_o,    1'b0);
        chk("rd_accept_c1", bus.mem_accept_o, 1'b0);
        idle_cycles(1);
        chk("rd_ack_c2",  bus.mem_ack_o,  1'b1);
        chk("rd_data_c2", bus.mem_data_o, 32'hDEAD_BEEF);
        chk("rd_last_c2", bus.mem_last_o, 1'b1);

        // Byte-lane merge.
        req(32'h0000_0104, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        req(32'h0000_0104, 32'h00AA_0000, 4'h4, 1'b0, 1'b0);
        req(32'h0000_0104, 32'd0, 4'h0, 1'b1, 1'b0);
        idle_cycles(1);
        chk("lane_data", bus.mem_data_o, 32'h11AA_3344);

        // Wrapping burst starting at the third word of a line.
        for (int i = 0; i < 4; i++) req(32'h200 + 4*i, i, 4'hF, 1'b0, 1'b0);
        req(32'h0000_0208, 32'd0, 4'h0, 1'b1, 1'b1);
        chk("burst_accept_c1", bus.mem_accept_o, 1'b0);
        chk("burst_ack_c1",    bus.mem_ack_o,    1'b0);
        burst_exp[0] = 32'd2;
        burst_exp[1] = 32'd3;
        burst_exp[2] = 32'd0;
        burst_exp[3] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            idle_cycles(1);
            chk("burst_ack",    bus.mem_ack_o,    1'b1);
            chk("burst_data",   bus.mem_data_o,   burst_exp[k]);
            chk("burst_last",   bus.mem_last_o,   k == 3);
            chk("burst_accept", bus.mem_accept_o, k == 3);
        end

        // Back-to-back writes, then reads queued behind a busy controller.
        for (int i = 0; i < 8; i++) req(32'h300 + 4*i, $urandom, 4'hF, 1'b0, 1'b0);
        req(32'h0000_0300, 32'd0, 4'h0, 1'b1, 1'b0);
        req(32'h0000_0304, 32'd0, 4'h0, 1'b1, 1'b1);
        req(32'h0000_0318, 32'd0, 4'h0, 1'b1, 1'b0);
        idle_cycles(3);

        // Reset in the middle of a burst.
        req(32'h0000_0200, 32'd0, 4'h0, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack",    bus.mem_ack_o,    1'b0);
        chk("mid_rst_last",   bus.mem_last_o,   1'b0);
        chk("mid_rst_data",   bus.mem_data_o,   32'd0);
        chk("mid_rst_accept", bus.mem_accept_o, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(6);
        req(32'h0000_0100, 32'd0, 4'h0, 1'b1, 1'b0);
        idle_cycles(1);
        chk("post_rst_data", bus.mem_data_o, 32'hDEAD_BEEF);
        chk("post_rst_last", bus.mem_last_o, 1'b1);

        // Randomized traffic over a small aliased window.
        for (int i = 0; i < 64; i++) begin
            a = $urandom;
            a[SIZE+1:2] = SIZE'(i);
            req(a, $urandom, 4'hF, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            a[SIZE+1:2] = SIZE'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0)
                req(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom), 1'($urandom));
            else
                req(a, $urandom, 4'h0, 1'b1, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bus_ctrl.md
# ram_bus_ctrl

Bus-side controller that sits directly upstream of port A of the dual-port byte-lane RAM (four 8-bit dual-port RAM lanes forming one 32-bit word). It accepts 32-bit CPU/cache memory requests and translates them into per-lane RAM address, data and write strobes. It absorbs the RAM's one-cycle registered-address read latency and returns registered read data with an acknowledge. It also supports 4-beat wrapping read bursts for cache line fills. Port B of the RAM is owned by other logic (loader/debug) and is outside this block.

## Interface
- SIZE, 14, RAM word-address width (lane depth 2^SIZE words)
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mem_addr_i  in  32  byte address; word address = mem_addr_i[SIZE+1:2]; other bits ignored (aliasing)
- mem_data_i  in  32  write data
- mem_wr_i  in  4  byte-lane write strobes; bit n writes mem_data_i[8n+7:8n]
- mem_rd_i  in  1  read request
- mem_burst_i  in  1  qualifies mem_rd_i as a 4-beat wrapping burst
- mem_accept_o  out  1  request accepted on this edge when high
- mem_data_o  out  32  registered read data
- mem_ack_o  out  1  one-cycle pulse per completed write or read beat
- mem_last_o  out  1  high with the final ack of a burst; high with every single-access ack
- ram_addr_o  out  SIZE  word address to all four lanes
- ram_data_o  out  32  write data to lanes (lane n = bits 8n+7:8n)
- ram_wr_o  out  4  per-lane write enable
- ram_data_i  in  32  concatenated lane read data

## Operation
- States: IDLE, RD, BURST, LAST.
- mem_accept_o = (state == IDLE), combinational. Requests when accept low are ignored, not queued; requester holds them.
- Request present = (mem_wr_i != 0) or mem_rd_i. Write has priority; mem_rd_i/mem_burst_i ignored when any mem_wr_i bit is set.
- IDLE, write: ram_addr_o = word addr, ram_data_o = mem_data_i, ram_wr_o = mem_wr_i combinationally; lanes written on the edge; ack/last registered high next cycle; stay IDLE.
- IDLE, single read: ram_addr_o = word addr, ram_wr_o = 0; go RD. In RD, mem_data_o <= ram_data_i at the edge; ack/last high next cycle; RD -> IDLE.
- IDLE, burst read: latch base = word addr; beat counter cnt <= 1; go BURST. Beat k address = {base[SIZE-1:2], base[1:0] + k} (2-bit wrap inside 4-word line, critical word first).
- BURST: ram_addr_o = beat cnt address; each edge capture ram_data_i into mem_data_o, ack next cycle, cnt <= cnt + 1; when cnt == 3 go LAST.
- LAST: capture final beat; ack and last high next cycle; go IDLE.
- ram_wr_o is 0 in every state except IDLE with an accepted write.
- ram_addr_o outside the above cases = word addr of mem_addr_i (don't-care for RAM, held deterministic).
- Reset (any time, incl. mid-burst): state IDLE, cnt 0, base 0, mem_data_o 0, mem_ack_o 0, mem_last_o 0; an interrupted burst produces no further acks.

## Timing
- Write: request accepted edge 0 -> RAM written edge 0 -> ack cycle 1. Back-to-back writes every cycle.
- Single read: accept edge 0 (RAM latches address) -> data registered edge 1 -> ack cycle 2. Next request accepted earliest edge 2 (cycle 1 accept low, in RD; ack cycle 2 coincides with accept high).
- Burst: accept edge 0; beat k address presented cycle k, data registered edge k+1, ack cycles 2..5 on consecutive cycles; last in cycle 5; accept low cycles 1..4, high cycle 5.
- mem_data_o holds its value until the next capture.
- Write and read at same address, write first: read returns new data (write lands edge 0, read accepted edge 1 or later).

## Test plan
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately, accept high after release.
- Write 0xDEADBEEF to 0x100 (wr=0xF), then single read 0x100 -> ack two cycles after read accept, mem_data_o = 0xDEADBEEF, last high.
- Byte lanes: write 0x11223344 full, then wr=0x4 data 0x00AA0000 -> read returns 0x11AA3344.
- Burst from 0x208 after filling words 0x200..0x20C with 0,1,2,3 -> acks on 4 consecutive cycles with data 2,3,0,1; last only on 4th; accept low during cycles 1..4.
- Back-to-back: 8 writes on consecutive cycles -> 8 consecutive acks; read during RD/BURST held by requester accepted only when accept high.
- Reset asserted in cycle 2 of a burst -> no further acks, state IDLE, mem_data_o 0; subsequent single read completes normally.
